sap1_ram_loader: RTL and testbench
==================================

Name: sap1_ram_loader

Overview:
- Writer side of the SAP-1 program memory: fills the 16x8 memory that the SAP-1 fetch path reads through MAR/ROM.
- Accepts a framed byte stream on a valid/ready input. The source is a UART RX or a host bridge, built separately.
- Issues single-cycle memory writes and holds the CPU in clear while a load is in progress.
- Releases the CPU only after a frame whose checksum is correct.

Parameters:
ADDR_W, 4, memory address width (16 words)
DATA_W, 8, memory word / stream byte width
HEADER, 8'hA5, frame start byte
TIMEOUT_CYCLES, 1000000, maximum CLK cycles between accepted bytes inside a frame before the frame is aborted

Ports:
CLK  in  1  system clock; all logic on rising edge
CLR_bar  in  1  synchronous active-low reset
in_data  in  8  stream byte
in_valid  in  1  in_data valid
in_ready  out  1  loader accepts a byte; a byte transfers when in_valid && in_ready at a rising edge
ram_addr  out  ADDR_W  write address
ram_data  out  DATA_W  write data
ram_we  out  1  write strobe, one cycle per data byte
cpu_hold  out  1  1 holds the SAP-1 in clear (drives CLR/CLR_bar gating upstream)
busy  out  1  1 while not in IDLE
load_done  out  1  one-cycle pulse after a good frame
load_error  out  1  sticky error flag

Behaviour:
- Reset (CLR_bar=0 at a rising edge) overrides everything, including a frame in progress. Reset values:
  - state=IDLE; in_ready=0; ram_we=0; ram_addr=0; ram_data=0
  - cpu_hold=0; busy=0; load_done=0; load_error=0
  - checksum=0; timeout count=0
- in_ready=1 in every state from the first cycle after reset is released. The loader never stalls the stream.
- Frame format: HEADER, COUNT, ADDR, DATA[0..COUNT-1], CSUM.
- IDLE:
  - Byte == HEADER: go to COUNT, cpu_hold<=1, load_error<=0, checksum<=0.
  - Any other byte: discarded, no state change.
- COUNT:
  - Byte in 1..16: latch count, checksum+=byte, go to ADDR.
  - Byte 0 or >16: load_error<=1, go to IDLE. cpu_hold stays 1.
- ADDR:
  - addr<=byte[ADDR_W-1:0]; upper bits are ignored but included in the checksum.
  - checksum+=byte; go to DATA.
- DATA, each accepted byte:
  - Next cycle: ram_we=1, ram_addr=addr, ram_data=byte (one-cycle write latency).
  - addr<=addr+1 mod 16; wraps 15->0.
  - checksum+=byte (mod 256); remaining count decrements.
  - After the last data byte: go to CSUM.
- Back-to-back bytes produce ram_we high on consecutive cycles.
- CSUM:
  - Byte == checksum: load_done pulses 1 cycle, cpu_hold<=0 (same edge), go to IDLE.
  - Mismatch: load_error<=1, cpu_hold stays 1, go to IDLE.
- Checksum: 8-bit wrapping sum of the COUNT, ADDR and all DATA bytes.
- cpu_hold after an error or timeout stays 1 until a later frame completes with a good checksum. Memory may be partially written.
- A HEADER value inside COUNT/ADDR/DATA/CSUM is treated as ordinary data.
- Timeout:
  - The counter runs in every non-IDLE state and clears on each accepted byte.
  - When it reaches TIMEOUT_CYCLES-1: go to IDLE, load_error<=1, cpu_hold stays 1.
- busy = (state != IDLE), registered with the state.

Decomposition:
- Package sap1_loader_pkg:
  - state enum (IDLE, COUNT, ADDR, DATA, CSUM)
  - HEADER_DEFAULT=8'hA5
  - MAX_COUNT=16
  - ADDR_W/DATA_W defaults
- One sub-module: sap1_loader_timeout, an inter-byte watchdog counter with inputs enable/clear and output expired.
- The main module holds the FSM, checksum, address counter and the write register.

Test Plan:
- Good frame: stream A5 02 03 11 22 38, one byte/cycle.
  - ram_we pulses 2 cycles: (3,11) then (4,22).
  - load_done pulses 1 cycle; cpu_hold 1->0; load_error=0.
- Wrap-around: A5 03 0F 01 02 03 18.
  - Writes (F,01), (0,02), (1,03).
  - load_done pulses.
- Bad checksum: A5 01 05 AA 00.
  - One write (5,AA); load_error=1; cpu_hold stays 1; no load_done.
  - A following good frame A5 01 05 BB C1 clears load_error at its HEADER and releases cpu_hold.
- Illegal count: A5 00.
  - load_error=1, state IDLE, no ram_we.
  - Same result for A5 11.
  - Stray byte 3C in IDLE: no change.
- Timeout with TIMEOUT_CYCLES=8: A5 01 then idle 10 cycles.
  - load_error=1 after 8 cycles; busy=0; cpu_hold=1.
- Reset mid-frame: CLR_bar=0 during DATA.
  - All outputs return to reset values next edge; cpu_hold=0.
  - The next non-HEADER byte is discarded.

Source files
------------

// File: rtl/sap1_loader_pkg.sv
// Shared types and constants for the SAP-1 program-memory loader.
// Frame: HEADER, COUNT, ADDR, DATA[0..COUNT-1], CSUM (8-bit wrapping sum of COUNT..DATA).
package sap1_loader_pkg;

    localparam int         ADDR_W_DEFAULT  = 4;
    localparam int         DATA_W_DEFAULT  = 8;
    localparam logic [7:0] HEADER_DEFAULT  = 8'hA5;
    localparam int         MAX_COUNT       = 16;
    localparam int         TIMEOUT_DEFAULT = 1000000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DATA  = 3'd3,
        ST_CSUM  = 3'd4
    } state_e;

    function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
        return sum + b;
    endfunction

    function automatic logic count_legal(input logic [7:0] b);
        return (b != 8'd0) && (b <= 8'(MAX_COUNT));
    endfunction

endpackage

// File: rtl/sap1_loader_timeout.sv
// Inter-byte watchdog: counts cycles while enabled, restarts on every accepted byte,
// and flags expiry on the cycle the count sits at TIMEOUT_CYCLES-1.
module sap1_loader_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic CLK,
    input  logic CLR_bar,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_expired = i_enable && !i_clear && (r_cnt == LAST);

    // Cycle counter, cleared outside a frame, on each byte and once it expires.
    always_ff @(posedge CLK) begin
        if (!CLR_bar) begin
            r_cnt <= '0;
        end else if (!i_enable || i_clear || o_expired) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sap1_ram_loader.sv
// Frame receiver that writes the SAP-1 16x8 program memory and holds the CPU in clear
// until a frame with a good checksum has been loaded.
module sap1_ram_loader
    import sap1_loader_pkg::*;
#(
    parameter int                ADDR_W         = ADDR_W_DEFAULT,
    parameter int                DATA_W         = DATA_W_DEFAULT,
    parameter logic [DATA_W-1:0] HEADER         = HEADER_DEFAULT,
    parameter int                TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic              CLK,
    input  logic              CLR_bar,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_we,
    output logic              cpu_hold,
    output logic              busy,
    output logic              load_done,
    output logic              load_error
);

    localparam int CNT_W = $clog2(MAX_COUNT) + 1;

    state_e            r_state;
    state_e            w_state_next;
    logic              r_in_ready;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_data;
    logic              r_cpu_hold;
    logic              r_busy;
    logic              r_load_done;
    logic              r_load_error;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_csum;
    logic [CNT_W-1:0]  r_remaining;

    logic              w_accept;
    logic              w_enable;
    logic              w_expired;
    logic              w_is_header;
    logic              w_count_ok;
    logic              w_last_data;
    logic              w_csum_ok;
    logic [DATA_W-1:0] w_csum_sum;

    assign w_accept    = in_valid && r_in_ready;
    assign w_enable    = (r_state != ST_IDLE);
    assign w_is_header = (in_data == HEADER);
    assign w_count_ok  = count_legal(in_data);
    assign w_last_data = (r_remaining == CNT_W'(1));
    assign w_csum_ok   = (in_data == r_csum);
    assign w_csum_sum  = csum_add(r_csum, in_data);

    sap1_loader_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .CLK      (CLK),
        .CLR_bar  (CLR_bar),
        .i_enable (w_enable),
        .i_clear  (w_accept),
        .o_expired(w_expired)
    );

    // Frame sequencing; a timeout abandons the frame from any state.
    always_comb begin
        w_state_next = r_state;
        if (w_expired) begin
            w_state_next = ST_IDLE;
        end else if (w_accept) begin
            case (r_state)
                ST_IDLE:  w_state_next = w_is_header ? ST_COUNT : ST_IDLE;
                ST_COUNT: w_state_next = w_count_ok ? ST_ADDR : ST_IDLE;
                ST_ADDR:  w_state_next = ST_DATA;
                ST_DATA:  w_state_next = w_last_data ? ST_CSUM : ST_DATA;
                ST_CSUM:  w_state_next = ST_IDLE;
                default:  w_state_next = ST_IDLE;
            endcase
        end else begin
            w_state_next = r_state;
        end
    end

    // State, status flags, checksum, address counter and the memory write register.
    always_ff @(posedge CLK) begin
        if (!CLR_bar) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_in_ready   <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_data   <= '0;
            r_cpu_hold   <= 1'b0;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
            r_addr       <= '0;
            r_csum       <= '0;
            r_remaining  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_busy      <= (w_state_next != ST_IDLE);
            r_in_ready  <= 1'b1;
            r_ram_we    <= 1'b0;
            r_load_done <= 1'b0;
            if (w_expired) begin
                r_load_error <= 1'b1;
            end else if (w_accept) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_is_header) begin
                            r_cpu_hold   <= 1'b1;
                            r_load_error <= 1'b0;
                            r_csum       <= '0;
                        end
                    end
                    ST_COUNT: begin
                        if (w_count_ok) begin
                            r_remaining <= CNT_W'(in_data);
                            r_csum      <= w_csum_sum;
                        end else begin
                            r_load_error <= 1'b1;
                        end
                    end
                    ST_ADDR: begin
                        r_addr <= in_data[ADDR_W-1:0];
                        r_csum <= w_csum_sum;
                    end
                    ST_DATA: begin
                        r_ram_we    <= 1'b1;
                        r_ram_addr  <= r_addr;
                        r_ram_data  <= in_data;
                        r_addr      <= r_addr + ADDR_W'(1);
                        r_csum      <= w_csum_sum;
                        r_remaining <= r_remaining - CNT_W'(1);
                    end
                    ST_CSUM: begin
                        // The CPU is only released here; errors leave it held.
                        if (w_csum_ok) begin
                            r_load_done <= 1'b1;
                            r_cpu_hold  <= 1'b0;
                        end else begin
                            r_load_error <= 1'b1;
                        end
                    end
                    default: begin
                        r_load_error <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign ram_we     = r_ram_we;
    assign ram_addr   = r_ram_addr;
    assign ram_data   = r_ram_data;
    assign cpu_hold   = r_cpu_hold;
    assign busy       = r_busy;
    assign load_done  = r_load_done;
    assign load_error = r_load_error;

endmodule

// File: tb/tb_sap1_ram_loader.sv
// Bench for sap1_ram_loader: directed vector table, then random framed traffic
// checked against a frame-position reference model.
module tb_sap1_ram_loader;

    localparam int TO = 8;

    logic       CLK;
    logic       CLR_bar;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] ram_addr;
    logic [7:0] ram_data;
    logic       ram_we;
    logic       cpu_hold;
    logic       busy;
    logic       load_done;
    logic       load_error;

    int n_assert = 0;
    int n_fail   = 0;

    sap1_ram_loader #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK       (CLK),
        .CLR_bar   (CLR_bar),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .ram_we    (ram_we),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .load_done (load_done),
        .load_error(load_error)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst_n;
        logic       valid;
        logic [7:0] data;
        logic       e_we;
        logic [3:0] e_addr;
        logic [7:0] e_data;
        logic       e_hold;
        logic       e_busy;
        logic       e_done;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic addv(input logic r, input logic v, input logic [7:0] d, input logic we,
                        input logic [3:0] a, input logic [7:0] wd, input logic h,
                        input logic b, input logic dn, input logic er);
        vec_t x;
        x.rst_n = r; x.valid = v; x.data = d; x.e_we = we; x.e_addr = a; x.e_data = wd;
        x.e_hold = h; x.e_busy = b; x.e_done = dn; x.e_err = er;
        vecs.push_back(x);
    endtask

    task automatic fr(input logic [7:0] d, input logic h, input logic b, input logic dn, input logic er);
        addv(1'b1, 1'b1, d, 1'b0, 4'h0, 8'h00, h, b, dn, er);
    endtask

    task automatic wr(input logic [7:0] d, input logic [3:0] a);
        addv(1'b1, 1'b1, d, 1'b1, a, d, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic gp(input logic h, input logic b, input logic dn, input logic er);
        addv(1'b1, 1'b0, 8'h00, 1'b0, 4'h0, 8'h00, h, b, dn, er);
    endtask

    task automatic rs(input logic v, input logic [7:0] d);
        addv(1'b0, v, d, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic cycle(input logic r, input logic v, input logic [7:0] d);
        CLR_bar  = r;
        in_valid = v;
        in_data  = d;
        @(posedge CLK);
        #1;
    endtask

    // Reference model: position within the current frame (-1 = hunting for HEADER).
    int         pos, gap, cnt, base, sum;
    logic       m_ready, m_we, m_hold, m_busy, m_done, m_err;
    logic [3:0] m_addr;
    logic [7:0] m_data;

    task automatic model_step(input logic r, input logic v, input logic [7:0] d);
        logic acc;
        if (!r) begin
            m_ready = 1'b0; m_we = 1'b0; m_addr = 4'h0; m_data = 8'h00;
            m_hold = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
            pos = -1; gap = 0; sum = 0; cnt = 0; base = 0;
        end else begin
            acc     = v && m_ready;
            m_ready = 1'b1;
            m_we    = 1'b0;
            m_done  = 1'b0;
            if (pos >= 0 && !acc) begin
                gap++;
                if (gap >= TO) begin
                    pos   = -1;
                    m_err = 1'b1;
                end
            end else if (acc) begin
                gap = 0;
                if (pos < 0) begin
                    if (d == 8'hA5) begin
                        pos = 0; m_hold = 1'b1; m_err = 1'b0; sum = 0;
                    end
                end else if (pos == 0) begin
                    if (d >= 8'd1 && d <= 8'd16) begin
                        cnt = int'(d); sum = (sum + int'(d)) % 256; pos = 1;
                    end else begin
                        m_err = 1'b1; pos = -1;
                    end
                end else if (pos == 1) begin
                    base = int'(d) % 16; sum = (sum + int'(d)) % 256; pos = 2;
                end else if (pos < 2 + cnt) begin
                    m_we   = 1'b1;
                    m_addr = 4'((base + pos - 2) % 16);
                    m_data = d;
                    sum    = (sum + int'(d)) % 256;
                    pos++;
                end else begin
                    if (int'(d) == sum) begin
                        m_done = 1'b1; m_hold = 1'b0;
                    end else begin
                        m_err = 1'b1;
                    end
                    pos = -1;
                end
            end
            m_busy = (pos >= 0);
        end
    endtask

    task automatic send(input logic r, input logic v, input logic [7:0] d);
        cycle(r, v, d);
        model_step(r, v, d);
        chk("rnd.ready", in_ready, m_ready);
        chk("rnd.we", ram_we, m_we);
        chk("rnd.hold", cpu_hold, m_hold);
        chk("rnd.busy", busy, m_busy);
        chk("rnd.done", load_done, m_done);
        chk("rnd.err", load_error, m_err);
        if (m_we) begin
            chk("rnd.addr", ram_addr, m_addr);
            chk("rnd.data", ram_data, m_data);
        end
    endtask

    task automatic send_byte(input logic [7:0] d);
        int r;
        r = $urandom_range(0, 19);
        if (r >= 12 && r < 18) begin
            repeat ($urandom_range(1, 3)) send(1'b1, 1'b0, 8'h00);
        end else if (r == 18) begin
            repeat (TO + 1) send(1'b1, 1'b0, 8'h00);
        end else if (r == 19 && $urandom_range(0, 3) == 0) begin
            send(1'b0, 1'b1, d);
        end
        send(1'b1, 1'b1, d);
    endtask

    initial begin
        CLR_bar = 1'b0; in_valid = 1'b0; in_data = 8'h00;

        // Reset, then good frame
        rs(1'b0, 8'h00); gp(0, 0, 0, 0);
        fr(8'hA5, 1, 1, 0, 0); fr(8'h02, 1, 1, 0, 0); fr(8'h03, 1, 1, 0, 0);
        wr(8'h11, 4'h3); wr(8'h22, 4'h4); fr(8'h38, 0, 0, 1, 0); gp(0, 0, 0, 0);
        // Address wrap
        fr(8'hA5, 1, 1, 0, 0); fr(8'h03, 1, 1, 0, 0); fr(8'h0F, 1, 1, 0, 0);
        wr(8'h01, 4'hF); wr(8'h02, 4'h0); wr(8'h03, 4'h1); fr(8'h18, 0, 0, 1, 0);
        // Bad checksum, then recovery frame
        fr(8'hA5, 1, 1, 0, 0); fr(8'h01, 1, 1, 0, 0); fr(8'h05, 1, 1, 0, 0);
        wr(8'hAA, 4'h5); fr(8'h00, 1, 0, 0, 1); gp(1, 0, 0, 1);
        fr(8'hA5, 1, 1, 0, 0); fr(8'h01, 1, 1, 0, 0); fr(8'h05, 1, 1, 0, 0);
        wr(8'hBB, 4'h5); fr(8'hC1, 0, 0, 1, 0);
        // Illegal counts and a stray byte
        fr(8'hA5, 1, 1, 0, 0); fr(8'h00, 1, 0, 0, 1);
        fr(8'hA5, 1, 1, 0, 0); fr(8'h11, 1, 0, 0, 1); fr(8'h3C, 1, 0, 0, 1);
        // Timeout after COUNT
        fr(8'hA5, 1, 1, 0, 0); fr(8'h01, 1, 1, 0, 0);
        repeat (TO - 1) gp(1, 1, 0, 0);
        repeat (3) gp(1, 0, 0, 1);
        // Reset in DATA, then a non-header byte is discarded
        fr(8'hA5, 1, 1, 0, 0); fr(8'h01, 1, 1, 0, 0); fr(8'h03, 1, 1, 0, 0);
        wr(8'h11, 4'h3); rs(1'b1, 8'h22); fr(8'h22, 0, 0, 0, 0); fr(8'h05, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].rst_n, vecs[i].valid, vecs[i].data);
            chk($sformatf("v%0d.ready", i), in_ready, vecs[i].rst_n);
            chk($sformatf("v%0d.we", i), ram_we, vecs[i].e_we);
            chk($sformatf("v%0d.hold", i), cpu_hold, vecs[i].e_hold);
            chk($sformatf("v%0d.busy", i), busy, vecs[i].e_busy);
            chk($sformatf("v%0d.done", i), load_done, vecs[i].e_done);
            chk($sformatf("v%0d.err", i), load_error, vecs[i].e_err);
            if (vecs[i].e_we || !vecs[i].rst_n) begin
                chk($sformatf("v%0d.addr", i), ram_addr, vecs[i].e_addr);
                chk($sformatf("v%0d.data", i), ram_data, vecs[i].e_data);
            end
        end

        // Random framed traffic against the model
        send(1'b0, 1'b0, 8'h00);
        send(1'b1, 1'b0, 8'h00);
        for (int f = 0; f < 80; f++) begin
            int         kind;
            int         n;
            logic [7:0] s;
            logic [7:0] b;
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h5A;
                send_byte(b);
            end else if (kind == 1) begin
                send_byte(8'hA5);
                b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(17, 255));
                send_byte(b);
            end else begin
                n = $urandom_range(1, 16);
                send_byte(8'hA5);
                s = 8'(n);
                send_byte(8'(n));
                b = 8'($urandom_range(0, 255));
                s = s + b;
                send_byte(b);
                for (int k = 0; k < n; k++) begin
                    b = 8'($urandom_range(0, 255));
                    s = s + b;
                    send_byte(b);
                end
                if (kind == 2) s = s ^ 8'($urandom_range(1, 255));
                send_byte(s);
            end
        end
        repeat (TO + 2) send(1'b1, 1'b0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
